// File: rtl/endian_swapper_param.sv
// Inline Avalon-ST byte-order converter: swaps bytes within aligned groups using a
// per-packet latched config, with a registered-ready skid buffer and CSR counters.
module endian_swapper_param #(
  parameter int DATA_BYTES  = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BYTES*8-1:0]       stream_in_data,
  input  logic [$clog2(DATA_BYTES)-1:0] stream_in_empty,
  input  logic                          stream_in_valid,
  input  logic                          stream_in_startofpacket,
  input  logic                          stream_in_endofpacket,
  output logic                          stream_in_ready,
  output logic [DATA_BYTES*8-1:0]       stream_out_data,
  output logic [$clog2(DATA_BYTES)-1:0] stream_out_empty,
  output logic                          stream_out_valid,
  output logic                          stream_out_startofpacket,
  output logic                          stream_out_endofpacket,
  input  logic                          stream_out_ready,
  input  logic [2:0]                    csr_address,
  input  logic                          csr_read,
  input  logic                          csr_write,
  input  logic [31:0]                   csr_writedata,
  output logic [31:0]                   csr_readdata,
  output logic                          csr_readdatavalid,
  output logic                          csr_waitrequest
);

  localparam int DW = DATA_BYTES * 8;
  localparam int EW = $clog2(DATA_BYTES);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
    logic          sop;
    logic          eop;
  } beat_t;

  logic [4:0]             ctrl_q, cfg_q, cfg_d, eff_cfg;
  logic                   in_packet_q, in_packet_d;
  logic                   in_fire, err_evt, csr_wr_en, clear;
  logic [EW-1:0]          mask;
  logic [DW-1:0]          swapped;
  logic [7:0]             in_bytes [DATA_BYTES];
  beat_t                  in_beat, out_q, out_d, skid_q, skid_d;
  logic                   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q;
  logic [COUNT_WIDTH-1:0] pkt_q, pkt_d, beat_q, beat_d, err_q, err_d;
  logic [31:0]            csr_readdata_q, rd_mux;
  logic                   csr_readdatavalid_q;
  logic                   unused_wdata;

  // Bit b of the XOR mask is set when the group size exceeds 2^b; gran beyond
  // the beat width saturates to a full-beat reversal.
  function automatic logic [EW-1:0] swap_mask(input logic [4:0] cfg);
    logic [EW-1:0] m;
    m = '0;
    for (int b = 0; b < EW; b++) begin
      if (cfg[0] && (int'(cfg[4:1]) > b)) m[b] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign in_fire   = stream_in_valid & in_ready_q;
  assign eff_cfg   = (in_packet_q && !stream_in_startofpacket) ? cfg_q : ctrl_q;
  assign mask      = swap_mask(eff_cfg);
  assign csr_wr_en = csr_write & ~csr_read;
  assign clear     = csr_wr_en && (csr_address == 3'd4);
  assign err_evt   = in_fire && (stream_in_startofpacket == in_packet_q);
  assign unused_wdata = ^csr_writedata[31:5];

  // Reversing within an aligned power-of-two group is an XOR of the byte index.
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_bytes
    localparam logic [EW-1:0] IDX = EW'(gi);
    assign in_bytes[gi]         = stream_in_data[gi*8 +: 8];
    assign swapped[gi*8 +: 8]   = in_bytes[IDX ^ mask];
  end

  assign in_beat = '{data: swapped, empty: stream_in_empty,
                     sop: stream_in_startofpacket, eop: stream_in_endofpacket};

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || stream_out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = in_fire;
        if (in_fire) skid_d = in_beat;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_d = in_beat;
      end
    end else if (in_fire) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    cfg_d       = cfg_q;
    in_packet_d = in_packet_q;
    if (in_fire) begin
      if (stream_in_startofpacket) begin
        cfg_d       = ctrl_q;
        in_packet_d = ~stream_in_endofpacket;
      end else if (stream_in_endofpacket) begin
        in_packet_d = 1'b0;
      end
    end
    pkt_d  = pkt_q;
    beat_d = beat_q;
    err_d  = err_q;
    if (clear) begin
      pkt_d  = '0;
      beat_d = '0;
      err_d  = '0;
    end else begin
      if (in_fire && stream_in_endofpacket) pkt_d = sat_inc(pkt_q);
      if (in_fire)                          beat_d = sat_inc(beat_q);
      if (err_evt)                          err_d = sat_inc(err_q);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      3'd0:    rd_mux = {27'd0, ctrl_q};
      3'd1:    rd_mux = 32'(pkt_q);
      3'd2:    rd_mux = 32'(beat_q);
      3'd3:    rd_mux = 32'(err_q);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q               <= '0;
      out_valid_q         <= 1'b0;
      skid_q              <= '0;
      skid_valid_q        <= 1'b0;
      in_ready_q          <= 1'b0;
      ctrl_q              <= '0;
      cfg_q               <= '0;
      in_packet_q         <= 1'b0;
      pkt_q               <= '0;
      beat_q              <= '0;
      err_q               <= '0;
      csr_readdata_q      <= '0;
      csr_readdatavalid_q <= 1'b0;
    end else begin
      out_q               <= out_d;
      out_valid_q         <= out_valid_d;
      skid_q              <= skid_d;
      skid_valid_q        <= skid_valid_d;
      in_ready_q          <= ~skid_valid_d;
      cfg_q               <= cfg_d;
      in_packet_q         <= in_packet_d;
      pkt_q               <= pkt_d;
      beat_q              <= beat_d;
      err_q               <= err_d;
      csr_readdatavalid_q <= csr_read;
      if (csr_read) csr_readdata_q <= rd_mux;
      if (csr_wr_en && (csr_address == 3'd0)) ctrl_q <= csr_writedata[4:0];
    end
  end

  assign stream_in_ready          = in_ready_q;
  assign stream_out_data          = out_q.data;
  assign stream_out_empty         = out_q.empty;
  assign stream_out_startofpacket = out_q.sop;
  assign stream_out_endofpacket   = out_q.eop;
  assign stream_out_valid         = out_valid_q;
  assign csr_readdata             = csr_readdata_q;
  assign csr_readdatavalid        = csr_readdatavalid_q;
  assign csr_waitrequest          = reset;

endmodule

// File: tb/tb_endian_swapper_param.sv
// Directed bench for endian_swapper_param: an 8-byte instance for most scenarios
// and a 16-byte instance with 2-bit counters for group swapping and saturation.
module tb_endian_swapper_param;

  typedef struct {
    logic [63:0] d;
    logic        s;
    logic        e;
  } exp_t;

  logic        clk, reset;
  logic [63:0] s_data;
  logic [2:0]  s_empty;
  logic        s_valid, s_sop, s_eop, in_ready;
  logic [63:0] out_data;
  logic [2:0]  out_empty;
  logic        out_valid, out_sop, out_eop, out_ready;
  logic [2:0]  c_addr;
  logic        c_read, c_write;
  logic [31:0] c_wdata, c_rdata;
  logic        c_rdv, c_wait;

  logic [127:0] b_data, b_out_data;
  logic [3:0]   b_empty, b_out_empty;
  logic         b_valid, b_sop, b_eop, b_in_ready;
  logic         b_out_valid, b_out_sop, b_out_eop, b_out_ready;
  logic [2:0]   b_addr;
  logic         b_read, b_write;
  logic [31:0]  b_wdata, b_rdata;
  logic         b_rdv, b_wait;

  int n_checks = 0;
  int n_fail   = 0;

  endian_swapper_param #(.DATA_BYTES(8), .COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .stream_in_data(s_data), .stream_in_empty(s_empty), .stream_in_valid(s_valid),
    .stream_in_startofpacket(s_sop), .stream_in_endofpacket(s_eop), .stream_in_ready(in_ready),
    .stream_out_data(out_data), .stream_out_empty(out_empty), .stream_out_valid(out_valid),
    .stream_out_startofpacket(out_sop), .stream_out_endofpacket(out_eop), .stream_out_ready(out_ready),
    .csr_address(c_addr), .csr_read(c_read), .csr_write(c_write), .csr_writedata(c_wdata),
    .csr_readdata(c_rdata), .csr_readdatavalid(c_rdv), .csr_waitrequest(c_wait)
  );

  endian_swapper_param #(.DATA_BYTES(16), .COUNT_WIDTH(2)) dut16 (
    .clk(clk), .reset(reset),
    .stream_in_data(b_data), .stream_in_empty(b_empty), .stream_in_valid(b_valid),
    .stream_in_startofpacket(b_sop), .stream_in_endofpacket(b_eop), .stream_in_ready(b_in_ready),
    .stream_out_data(b_out_data), .stream_out_empty(b_out_empty), .stream_out_valid(b_out_valid),
    .stream_out_startofpacket(b_out_sop), .stream_out_endofpacket(b_out_eop), .stream_out_ready(b_out_ready),
    .csr_address(b_addr), .csr_read(b_read), .csr_write(b_write), .csr_writedata(b_wdata),
    .csr_readdata(b_rdata), .csr_readdatavalid(b_rdv), .csr_waitrequest(b_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic csr_wr(input bit b16, input logic [2:0] a, input logic [31:0] d);
    if (b16) begin b_addr = a; b_wdata = d; b_write = 1'b1; end
    else     begin c_addr = a; c_wdata = d; c_write = 1'b1; end
    @(posedge clk); #1;
    c_write = 1'b0; b_write = 1'b0;
    $display("csr write dut%0d addr=%0d data=%h", b16 ? 16 : 8, a, d);
  endtask

  task automatic csr_rd(input bit b16, input logic [2:0] a, output logic [31:0] d, output logic v);
    if (b16) begin b_addr = a; b_read = 1'b1; end
    else     begin c_addr = a; c_read = 1'b1; end
    @(posedge clk); #1;
    c_read = 1'b0; b_read = 1'b0;
    d = b16 ? b_rdata : c_rdata;
    v = b16 ? b_rdv : c_rdv;
    $display("csr read  dut%0d addr=%0d data=%h valid=%0b", b16 ? 16 : 8, a, d, v);
  endtask

  task automatic set_beat(input logic [63:0] d, input logic sop, input logic eop);
    s_data = d; s_empty = 3'd0; s_sop = sop; s_eop = eop; s_valid = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic rv;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_checks++; if ({out_valid, out_sop, out_eop, out_data, out_empty} !== 70'd0) begin
      n_fail++; $display("FAIL reset_out: got v=%b s=%b e=%b d=%h emp=%0d expected all zero", out_valid, out_sop, out_eop, out_data, out_empty); end
    n_checks++; if ({in_ready, c_rdv, c_rdata} !== 34'd0) begin
      n_fail++; $display("FAIL reset_ready_csr: got ready=%b rdv=%b rdata=%h expected 0", in_ready, c_rdv, c_rdata); end
    n_checks++; if (c_wait !== 1'b1) begin n_fail++; $display("FAIL reset_wait: got %b expected 1", c_wait); end
    reset = 1'b0;
    #1;
    n_checks++; if (c_wait !== 1'b0) begin n_fail++; $display("FAIL wait_release: got %b expected 0", c_wait); end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_release: got %b expected 1", in_ready); end
    csr_rd(0, 3'd0, rd, rv);
    n_checks++; if (rv !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h v=%b expected 0", rd, rv); end
    csr_rd(0, 3'd1, rd, rv);
    n_checks++; if (rv !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL reset_pkt: got %h v=%b expected 0", rd, rv); end
  endtask

  task automatic test_csr();
    logic [31:0] rd; logic rv;
    csr_wr(0, 3'd0, 32'hFFFF_FFFF);
    csr_rd(0, 3'd0, rd, rv);
    n_checks++; if (rv !== 1'b1 || rd !== 32'h1F) begin n_fail++; $display("FAIL ctrl_mask: got %h expected 0000001f", rd); end
    @(posedge clk); #1;
    n_checks++; if (c_rdv !== 1'b0) begin n_fail++; $display("FAIL rdv_one_cycle: got %b expected 0", c_rdv); end
    c_addr = 3'd0; c_wdata = 32'd0; c_read = 1'b1; c_write = 1'b1;
    @(posedge clk); #1;
    c_read = 1'b0; c_write = 1'b0;
    $display("csr read+write dut8 addr=0 data=%h", c_rdata);
    n_checks++; if (c_rdata !== 32'h1F) begin n_fail++; $display("FAIL rw_collide_read: got %h expected 0000001f", c_rdata); end
    csr_rd(0, 3'd0, rd, rv);
    n_checks++; if (rd !== 32'h1F) begin n_fail++; $display("FAIL rw_collide_drop: got %h expected 0000001f", rd); end
    csr_wr(0, 3'd5, 32'h1234_5678);
    csr_rd(0, 3'd4, rd, rv);
    n_checks++; if (rv !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL clear_read: got %h expected 0", rd); end
    csr_rd(0, 3'd6, rd, rv);
    n_checks++; if (rv !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", rd); end
    csr_wr(0, 3'd0, 32'h7);
  endtask

  task automatic test_swap64();
    logic [31:0] rd; logic rv;
    out_ready = 1'b1;
    s_data = 64'h0011223344556677; s_empty = 3'd3; s_sop = 1'b1; s_eop = 1'b1; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    $display("beat dut8 out=%h sop=%b eop=%b empty=%0d", out_data, out_sop, out_eop, out_empty);
    n_checks++; if ({out_valid, out_sop, out_eop, out_empty, out_data} !== {3'b111, 3'd3, 64'h7766554433221100}) begin
      n_fail++; $display("FAIL swap64: got v=%b s=%b e=%b emp=%0d d=%h expected 1 1 1 3 7766554433221100", out_valid, out_sop, out_eop, out_empty, out_data); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL swap64_drain: got %b expected 0", out_valid); end
    csr_rd(0, 3'd1, rd, rv);
    n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL swap64_pkt: got %0d expected 1", rd); end
    csr_rd(0, 3'd2, rd, rv);
    n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL swap64_beat: got %0d expected 1", rd); end
  endtask

  task automatic test_gran16();
    logic [31:0] rd; logic rv;
    csr_wr(1, 3'd0, 32'h5);
    b_out_ready = 1'b1;
    b_data = 128'h000102030405060708090A0B0C0D0E0F; b_empty = 4'd0; b_sop = 1'b1; b_eop = 1'b1; b_valid = 1'b1;
    n_checks++; if (b_in_ready !== 1'b1 || b_wait !== 1'b0) begin n_fail++; $display("FAIL g16_ready: got ready=%b wait=%b expected 1 0", b_in_ready, b_wait); end
    @(posedge clk); #1;
    $display("beat dut16 out=%h", b_out_data);
    n_checks++; if (b_out_valid !== 1'b1 || b_out_data !== 128'h03020100070605040B0A09080F0E0D0C) begin
      n_fail++; $display("FAIL g16_swap: got v=%b d=%h expected 1 03020100070605040b0a09080f0e0d0c", b_out_valid, b_out_data); end
    n_checks++; if ({b_out_sop, b_out_eop, b_out_empty} !== {2'b11, 4'd0}) begin
      n_fail++; $display("FAIL g16_ctl: got s=%b e=%b emp=%0d expected 1 1 0", b_out_sop, b_out_eop, b_out_empty); end
    repeat (4) @(posedge clk);
    #1;
    b_valid = 1'b0;
    csr_rd(1, 3'd2, rd, rv);
    n_checks++; if (rd !== 32'd3) begin n_fail++; $display("FAIL g16_beat_sat: got %0d expected 3", rd); end
    csr_rd(1, 3'd1, rd, rv);
    n_checks++; if (rd !== 32'd3) begin n_fail++; $display("FAIL g16_pkt_sat: got %0d expected 3", rd); end
  endtask

  task automatic test_latch();
    logic [31:0] rd; logic rv;
    logic [63:0] din [4];
    logic [63:0] dexp [4];
    din[0] = 64'h0102030405060708; dexp[0] = 64'h0807060504030201;
    din[1] = 64'h1112131415161718; dexp[1] = 64'h1817161514131211;
    din[2] = 64'h2122232425262728; dexp[2] = 64'h2827262524232221;
    din[3] = 64'h3132333435363738; dexp[3] = 64'h3837363534333231;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_beat(din[i], i == 0, i == 3);
      if (i == 2) begin c_addr = 3'd0; c_wdata = 32'd0; c_write = 1'b1; end
      @(posedge clk); #1;
      c_write = 1'b0;
      $display("beat dut8 latch[%0d] out=%h", i, out_data);
      n_checks++; if ({out_valid, out_sop, out_eop, out_data} !== {1'b1, i == 0, i == 3, dexp[i]}) begin
        n_fail++; $display("FAIL latch_beat%0d: got v=%b s=%b e=%b d=%h expected %h", i, out_valid, out_sop, out_eop, out_data, dexp[i]); end
      n_checks++; if (c_wait !== 1'b0) begin n_fail++; $display("FAIL latch_wait%0d: got %b expected 0", i, c_wait); end
    end
    set_beat(64'hA1A2A3A4A5A6A7A8, 1'b1, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    n_checks++; if (out_data !== 64'hA1A2A3A4A5A6A7A8) begin n_fail++; $display("FAIL latch_next_pass: got %h expected a1a2a3a4a5a6a7a8", out_data); end
    csr_rd(0, 3'd1, rd, rv);
    n_checks++; if (rd !== 32'd3) begin n_fail++; $display("FAIL latch_pkt: got %0d expected 3", rd); end
    csr_rd(0, 3'd2, rd, rv);
    n_checks++; if (rd !== 32'd6) begin n_fail++; $display("FAIL latch_beat: got %0d expected 6", rd); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    set_beat(64'hAAAA_0000_0000_0001, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_checks++; if ({out_valid, in_ready, out_data} !== {2'b11, 64'hAAAA_0000_0000_0001}) begin
      n_fail++; $display("FAIL stall_a: got v=%b r=%b d=%h expected 1 1 aaaa000000000001", out_valid, in_ready, out_data); end
    set_beat(64'hBBBB_0000_0000_0002, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++; if ({in_ready, out_data} !== {1'b0, 64'hAAAA_0000_0000_0001}) begin
      n_fail++; $display("FAIL stall_skid: got r=%b d=%h expected 0 aaaa000000000001", in_ready, out_data); end
    set_beat(64'hCCCC_0000_0000_0003, 1'b0, 1'b1);
    @(posedge clk); #1;
    n_checks++; if ({out_valid, in_ready, out_data} !== {2'b10, 64'hAAAA_0000_0000_0001}) begin
      n_fail++; $display("FAIL stall_hold: got v=%b r=%b d=%h expected 1 0 aaaa000000000001", out_valid, in_ready, out_data); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_comb_path: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    n_checks++; if ({in_ready, out_data} !== {1'b1, 64'hBBBB_0000_0000_0002}) begin
      n_fail++; $display("FAIL stall_skid_move: got r=%b d=%h expected 1 bbbb000000000002", in_ready, out_data); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    n_checks++; if ({out_valid, out_eop, out_data} !== {2'b11, 64'hCCCC_0000_0000_0003}) begin
      n_fail++; $display("FAIL stall_c: got v=%b e=%b d=%h expected 1 1 cccc000000000003", out_valid, out_eop, out_data); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b expected 0", out_valid); end
    $display("stall sequence dut8 done");
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic rv;
    csr_wr(0, 3'd4, 32'd0);
    csr_wr(0, 3'd0, 32'h7);
    out_ready = 1'b1;
    set_beat(64'h0102030405060708, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++; if ({out_valid, out_data} !== {1'b1, 64'h0807060504030201}) begin
      n_fail++; $display("FAIL err_idle_beat: got v=%b d=%h expected 1 0807060504030201", out_valid, out_data); end
    set_beat(64'hF0E0D0C0B0A09080, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_checks++; if ({out_valid, out_data} !== {1'b1, 64'h8090A0B0C0D0E0F0}) begin
      n_fail++; $display("FAIL err_sop1: got v=%b d=%h expected 1 8090a0b0c0d0e0f0", out_valid, out_data); end
    set_beat(64'h0011223344556677, 1'b1, 1'b0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    n_checks++; if ({out_valid, out_data} !== {1'b1, 64'h7766554433221100}) begin
      n_fail++; $display("FAIL err_sop2: got v=%b d=%h expected 1 7766554433221100", out_valid, out_data); end
    csr_rd(0, 3'd3, rd, rv);
    n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL err_count: got %0d expected 2", rd); end
    csr_rd(0, 3'd2, rd, rv);
    n_checks++; if (rd !== 32'd3) begin n_fail++; $display("FAIL err_beats: got %0d expected 3", rd); end
    set_beat(64'h5555_6666_7777_8888, 1'b0, 1'b1);
    c_addr = 3'd4; c_wdata = 32'd1; c_write = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; c_write = 1'b0;
    csr_rd(0, 3'd1, rd, rv);
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL clear_wins_pkt: got %0d expected 0", rd); end
    csr_rd(0, 3'd3, rd, rv);
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL clear_err: got %0d expected 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic rv;
    exp_t q[$];
    exp_t e;
    logic [63:0] cur_d, rev;
    int tx = 0;
    int rx = 0;
    int held = 0;
    int cyc = 0;
    csr_wr(0, 3'd4, 32'd0);
    csr_wr(0, 3'd0, 32'h7);
    cur_d = {$urandom, $urandom};
    while (rx < 1000 && cyc < 20000) begin
      s_data = cur_d; s_empty = 3'd0; s_sop = (tx % 4 == 0); s_eop = (tx % 4 == 3);
      s_valid = (tx < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1) == 1;
      @(negedge clk);
      n_checks++; if (in_ready === 1'b1 && held > 1) begin
        n_fail++; $display("FAIL ready_with_skid_full: got ready=1 with %0d beats held expected ready=0", held); end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_beat: got d=%h expected no beat", out_data);
        end else begin
          e = q.pop_front();
          if ({out_data, out_sop, out_eop} !== {e.d, e.s, e.e}) begin
            n_fail++; $display("FAIL b2b_beat%0d: got d=%h s=%b e=%b expected d=%h s=%b e=%b", rx, out_data, out_sop, out_eop, e.d, e.s, e.e); end
        end
        $display("beat dut8 b2b[%0d] out=%h", rx, out_data);
        rx++; held--;
      end
      if (s_valid && in_ready === 1'b1) begin
        rev = {<<8{cur_d}};
        q.push_back('{d: rev, s: s_sop, e: s_eop});
        tx++; held++;
        cur_d = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (rx != 1000) begin n_fail++; $display("FAIL b2b_timeout: got %0d beats expected 1000", rx); end
    csr_rd(0, 3'd1, rd, rv);
    n_checks++; if (rd !== 32'd250) begin n_fail++; $display("FAIL b2b_pkt: got %0d expected 250", rd); end
    csr_rd(0, 3'd2, rd, rv);
    n_checks++; if (rd !== 32'd1000) begin n_fail++; $display("FAIL b2b_beat: got %0d expected 1000", rd); end
    csr_rd(0, 3'd3, rd, rv);
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL b2b_err: got %0d expected 0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic rv;
    csr_wr(0, 3'd0, 32'h7);
    out_ready = 1'b0;
    set_beat(64'h1010_2020_3030_4040, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_beat(64'h5050_6060_7070_8080, 1'b0, 1'b0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full: got ready=%b expected 0", in_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({out_valid, out_sop, out_eop, out_data, in_ready, c_rdv} !== 69'd0) begin
      n_fail++; $display("FAIL rmid_clear: got v=%b s=%b e=%b d=%h r=%b rdv=%b expected all 0", out_valid, out_sop, out_eop, out_data, in_ready, c_rdv); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_release: got r=%b v=%b expected 1 0", in_ready, out_valid); end
    csr_rd(0, 3'd0, rd, rv);
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rmid_ctrl: got %h expected 0", rd); end
    csr_rd(0, 3'd2, rd, rv);
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rmid_beats: got %0d expected 0", rd); end
    out_ready = 1'b1;
    set_beat(64'h0123456789ABCDEF, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (out_data !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL rmid_pass0: got %h expected 0123456789abcdef", out_data); end
    set_beat(64'hFEDCBA9876543210, 1'b0, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    n_checks++; if ({out_eop, out_data} !== {1'b1, 64'hFEDCBA9876543210}) begin
      n_fail++; $display("FAIL rmid_pass1: got e=%b d=%h expected 1 fedcba9876543210", out_eop, out_data); end
    csr_rd(0, 3'd1, rd, rv);
    n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL rmid_pkt: got %0d expected 1", rd); end
  endtask

  initial begin
    reset = 1'b1;
    s_data = '0; s_empty = '0; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; out_ready = 1'b0;
    c_addr = '0; c_read = 1'b0; c_write = 1'b0; c_wdata = '0;
    b_data = '0; b_empty = '0; b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0; b_out_ready = 1'b0;
    b_addr = '0; b_read = 1'b0; b_write = 1'b0; b_wdata = '0;
    test_reset();
    test_csr();
    test_swap64();
    test_gran16();
    test_latch();
    test_stall();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/endian_swapper_param.md
# endian_swapper_param

Parametrised, fully pipelined byte-order converter for Avalon-ST packet streams of any power-of-two width, with selectable swap granularity, per-packet configuration latching, a registered-ready skid buffer, and statistics/error counters on an Avalon-MM CSR port. It sits inline on a packet datapath and replaces the fixed 64-bit swapper where the stream width or word size differs, or where CSR accesses must not stall on packet activity.

## Interface
- DATA_BYTES, 8, beat width in bytes; power of two, 2..128
- COUNT_WIDTH, 32, width of each statistics counter, 1..32; CSR reads zero-extend

- clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- stream_in_data  in  DATA_BYTES*8  first byte in MSBs
- stream_in_empty  in  $clog2(DATA_BYTES)  unused bytes in EOP beat, counted from LSB end
- stream_in_valid / stream_in_startofpacket / stream_in_endofpacket  in  1 each
- stream_in_ready  out  1  registered; readyLatency 0
- stream_out_data  out  DATA_BYTES*8
- stream_out_empty  out  $clog2(DATA_BYTES)
- stream_out_valid / stream_out_startofpacket / stream_out_endofpacket  out  1 each
- stream_out_ready  in  1
- csr_address  in  3  word address
- csr_read / csr_write  in  1 each
- csr_writedata  in  32
- csr_readdata  out  32  valid with csr_readdatavalid
- csr_readdatavalid  out  1  fixed read latency 1
- csr_waitrequest  out  1  high only while reset is high

## Operation
- CSR map: 0 CTRL [R/W]: bit0 enable, bits 4:1 gran, others read 0; 1 PKT_COUNT [RO]: accepted EOP beats; 2 BEAT_COUNT [RO]: accepted beats; 3 ERR_COUNT [RO]: protocol errors; 4 CLEAR [WO]: any write zeroes all three counters, reads return 0. Addresses 5-7: reads return 0, writes ignored.
- Group size G = min(2^gran, DATA_BYTES) bytes. When enable=1 and G>1, bytes reverse within each aligned G-byte group; otherwise data passes unchanged. gran=0 equals passthrough.
- empty, SOP, EOP are forwarded unchanged; no realignment of data for partial beats.
- Config latching: the active (enable, gran) pair is captured from CTRL on each accepted SOP beat and held until the next accepted SOP. Beats outside a packet use live CTRL. A CTRL write never affects a packet in flight.
- Packet tracking: in_packet sets on accepted SOP without EOP, clears on accepted EOP (single-beat SOP+EOP leaves it clear).
- Protocol errors (ERR_COUNT +1, beat still forwarded): accepted SOP while in_packet (treated as new packet start, config relatched); accepted non-SOP beat while !in_packet (uses live CTRL).
- Counters saturate at 2^COUNT_WIDTH-1. CLEAR in the same cycle as an increment: clear wins. Read in the same cycle as an increment returns pre-increment value.
- csr_read and csr_write in the same cycle: read is serviced, write dropped.
- Datapath: output register plus one-entry skid register. Beat accepted when stream_in_valid & stream_in_ready.

## Timing
- Reset (sampled at a clk edge while reset=1): stream_out_valid/SOP/EOP 0, stream_out_data 0, stream_out_empty 0, stream_in_ready 0, csr_readdata 0, csr_readdatavalid 0, CTRL 0, all counters 0, in_packet 0, skid empty. Asserting reset mid-packet discards both stored beats at once.
- First cycle after reset deasserts: stream_in_ready=1, csr_waitrequest=0.
- Latency: beat accepted at edge N is on stream_out_* from edge N (visible cycle N+1) when the output register is free; throughput 1 beat/clk with stream_out_ready held high.
- stream_in_ready = !skid_full, a flop output; never combinational from stream_out_ready.
- Stall: output held while valid & !ready; one further beat accepted into skid, then stream_in_ready drops the following cycle. On output accept, skid moves to output same edge; stream_in_ready returns 1 the next cycle. No beat lost, duplicated or reordered.
- CSR read issued at edge N: csr_readdatavalid=1 and csr_readdata valid for exactly cycle N+1. Writes take effect at the issuing edge; CTRL readback reflects them on the next read.

## Test plan
- DATA_BYTES=8, CTRL=0x1|(3<<1): single beat 0x0011223344556677 SOP+EOP -> out 0x7766554433221100 one cycle later; PKT_COUNT=1, BEAT_COUNT=1.
- DATA_BYTES=16, gran=2 (G=4): beat 0x00..0F ascending bytes -> 0x03020100_07060504_0B0A0908_0F0E0D0C.
- 4-beat packet, CTRL write enable=0 after beat 2 accepted -> all 4 beats swapped; next packet passthrough; csr_waitrequest stays 0 throughout.
- Random stream_out_ready toggling (~50%) over 1000 beats -> output sequence identical to input (modulo swap), stream_in_ready never high with skid full, no combinational path ready_out->ready_in.
- Non-SOP beat while idle, then SOP, SOP -> ERR_COUNT=2, all beats forwarded; CLEAR write coincident with an EOP -> PKT_COUNT reads 0.
- Reset asserted with skid full mid-packet -> next cycle all outputs 0, counters 0, stream_in_ready 0; following packet processed with CTRL=0 passthrough.
